muldiv_unit: RTL

//  Iterative RV32M multiply/divide unit for the execute stage. Takes two XLEN

---
 rtl/muldiv_unit.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// Multiplication uses shift-add and division is restoring. Both retire
// BITS_PER_CYCLE bits per CALC cycle. Divide-by-zero and signed divide
// overflow skip CALC and complete in one cycle.
// Ports:
//   clk_i, rstn_i       clock (rising edge), asynchronous active-low reset
//   valid_i / ready_o   request handshake (ready_o high only in IDLE)
//   op_i                M-extension func3
//   rs1_i, rs2_i        operand A (multiplicand/dividend), B (multiplier/divisor)
//   tag_i / tag_o       pass-through tag, captured on accept
//   kill_i              flush; aborts any operation and blocks accept
//   valid_o / ready_i   result handshake (valid_o high only in DONE)
//   result_o            registered result
module muldiv_unit #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned TAG_W          = 5
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       op_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  rs2_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             kill_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int unsigned N     = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [2*XLEN:0]   acc_q;
  logic [2*XLEN:0]   acc_step;
  logic [XLEN-1:0]   opnd_q;
  logic [2:0]        op_q;
  logic              res_neg_q;
  logic [TAG_W-1:0]  tag_q;
  logic [XLEN-1:0]   result_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              fin_q;

  // Request decode
  logic              accept;
  logic              a_signed, b_signed, a_neg, b_neg, res_neg_d;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res;

  assign ready_o  = (state_q == S_IDLE);
  assign valid_o  = (state_q == S_DONE);
  assign result_o = result_q;
  assign tag_o    = tag_q;
  assign accept   = valid_i & ready_o & ~kill_i;

  always_comb begin
    a_signed = (op_i == 3'b001) | (op_i == 3'b010) | (op_i == 3'b100) | (op_i == 3'b110);
    b_signed = (op_i == 3'b001) | (op_i == 3'b100) | (op_i == 3'b110);
    a_neg    = a_signed & rs1_i[XLEN-1];
    b_neg    = b_signed & rs2_i[XLEN-1];
    a_abs    = a_neg ? -rs1_i : rs1_i;
    b_abs    = b_neg ? -rs2_i : rs2_i;
    // REM/REMU follow the dividend sign; everything else follows sign(A)^sign(B)
    res_neg_d = (op_i[2] & op_i[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero  = op_i[2] & (rs2_i == '0);
    div_ovf   = op_i[2] & ~op_i[0] & (rs1_i == MIN_VAL) & (rs2_i == '1);
    special   = div_zero | div_ovf;
    if (div_zero) special_res = op_i[1] ? rs1_i : '1;
    else          special_res = op_i[1] ? '0 : MIN_VAL;
  end

  // One CALC step: BITS_PER_CYCLE shift-add or restoring-subtract iterations.
  // Multiply: acc = {hi(XLEN+1), multiplier}, add multiplicand into hi, shift right.
  // Divide:   acc = {rem(XLEN+1), dividend}, shift left, subtract divisor if it fits.
  always_comb begin
    acc_step = acc_q;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (op_q[2]) begin
        acc_step = acc_step << 1;
        if (acc_step[2*XLEN:XLEN] >= {1'b0, opnd_q}) begin
          acc_step[2*XLEN:XLEN] = acc_step[2*XLEN:XLEN] - {1'b0, opnd_q};
          acc_step[0] = 1'b1;
        end
      end else begin
        if (acc_step[0]) begin
          acc_step[2*XLEN:XLEN] = acc_step[2*XLEN:XLEN] + {1'b0, opnd_q};
        end
        acc_step = acc_step >> 1;
      end
    end
  end

  // Sign correction and word selection
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   div_sel, div_fix, calc_res;

  always_comb begin
    prod     = acc_q[2*XLEN-1:0];
    prod_fix = res_neg_q ? -prod : prod;
    div_sel  = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    div_fix  = res_neg_q ? -div_sel : div_sel;
    if (op_q[2])              calc_res = div_fix;
    else if (op_q[1:0] == 2'b00) calc_res = prod_fix[XLEN-1:0];
    else                      calc_res = prod_fix[2*XLEN-1:XLEN];
  end

  // FSM
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = special ? S_DONE : S_CALC;
      S_CALC:  if (fin_q) state_d = S_DONE;
      S_DONE:  if (ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (kill_i) state_d = S_IDLE;
  end

  // Datapath. After the step taken with cnt_q==0, fin_q gives one more CALC
  // cycle that registers the sign-corrected result (N+1 cycle latency).
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      acc_q     <= '0;
      opnd_q    <= '0;
      op_q      <= '0;
      res_neg_q <= 1'b0;
      tag_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      fin_q     <= 1'b0;
    end else if (!kill_i) begin
      if (accept) begin
        op_q      <= op_i;
        tag_q     <= tag_i;
        res_neg_q <= res_neg_d;
        cnt_q     <= CNT_W'(N - 1);
        fin_q     <= 1'b0;
        if (op_i[2]) begin
          acc_q  <= {{(XLEN+1){1'b0}}, a_abs};
          opnd_q <= b_abs;
        end else begin
          acc_q  <= {{(XLEN+1){1'b0}}, b_abs};
          opnd_q <= a_abs;
        end
        if (special) result_q <= special_res;
      end else if (state_q == S_CALC) begin
        if (fin_q) begin
          result_q <= calc_res;
        end else begin
          acc_q <= acc_step;
          cnt_q <= cnt_q - 1'b1;
          fin_q <= (cnt_q == '0);
        end
      end
    end
  end

endmodule
